uart_rx_buffer: RTL

//  Downstream stage of the UART receive engine: captures each received byte and its

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync_fifo.sv | 59 +++++
 rtl/uart_rx_buffer.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive buffer: port addresses, word layouts, capture FSM states.
package uart_pkg;

    localparam logic [15:0] UART_DATA_ADDR = 16'h0000;
    localparam logic [15:0] UART_STAT_ADDR = 16'h0001;

    // FIFO entry is {ovf, ferr, perr, byte}; the data word exposes it unchanged in [10:0]
    localparam int unsigned ENTRY_W       = 11;
    localparam int unsigned DATA_PERR_BIT = 8;
    localparam int unsigned DATA_FERR_BIT = 9;
    localparam int unsigned DATA_OVF_BIT  = 10;

    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_CNT_LSB   = 4;
    localparam int unsigned STAT_CNT_W     = 4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAck     = 2'd1,
        StWaitClr = 2'd2
    } cap_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; push ignored when full, pop ignored when empty.
module uart_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned WIDTH = 11
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_push    = i_push & ~o_full;
    assign w_pop     = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: stale entries are unreachable once the pointers clear
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: captures engine bytes into a FIFO, acks the engine, serves the read port.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AW        = 3,
    parameter logic [15:0] DATA_ADDR = UART_DATA_ADDR,
    parameter logic [15:0] STAT_ADDR = UART_STAT_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    input  logic        rx_perr,
    input  logic        rx_ferr,
    input  logic        rx_ovf,
    output logic        reads0,
    input  logic [15:0] port_id,
    input  logic        read_strobe,
    output logic [15:0] in_port,
    output logic        interrupt,
    input  logic        interrupt_ack
);

    cap_state_e           r_state;
    cap_state_e           w_state_next;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [AW:0]          w_count;
    logic [ENTRY_W-1:0]   w_wr_data;
    logic [ENTRY_W-1:0]   w_rd_data;
    logic                 r_interrupt;

    assign w_wr_data = {rx_ovf, rx_ferr, rx_perr, rx_data};
    assign w_pop     = read_strobe && (port_id == DATA_ADDR) && !w_empty;
    assign reads0    = (r_state == StAck);
    assign interrupt = r_interrupt;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_push    (w_push),
        .i_wr_data (w_wr_data),
        .i_pop     (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Push is gated on the pre-pop full flag, so a full FIFO takes one extra cycle after a pop
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            StIdle: begin
                if (rx_rdy && !w_full) begin
                    w_push       = 1'b1;
                    w_state_next = StAck;
                end
            end
            StAck: begin
                w_state_next = StWaitClr;
            end
            StWaitClr: begin
                if (!rx_rdy) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        in_port = '0;
        if (port_id == DATA_ADDR) begin
            if (!w_empty) begin
                in_port[ENTRY_W-1:0] = w_rd_data;
            end
        end else if (port_id == STAT_ADDR) begin
            in_port[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(w_count);
            in_port[STAT_FULL_BIT]              = w_full;
            in_port[STAT_EMPTY_BIT]             = w_empty;
        end
    end

    // A push in the same cycle as an ack wins, so no arrival is ever lost
    always_ff @(posedge clk) begin
        if (rst) begin
            r_interrupt <= 1'b0;
        end else if (w_push) begin
            r_interrupt <= 1'b1;
        end else if (interrupt_ack) begin
            r_interrupt <= 1'b0;
        end
    end

endmodule
